// File: rtl/clock_reset_gen.sv
// Clock/reset generator: per-channel clock dividers plus a stretched, button-driven SOC reset.
// Latency: clk_o/tick_o registered (same cycle as counter); button reaches soc_rst_n_o 3 edges after btn_i.
// Backpressure: none; free-running outputs, divisor loads always accepted.
//
// Optional feature macro: CLOCK_RESET_GEN_DEBOUNCE_EN
//   defined   -> synchronized button is debounced over DEBOUNCE_CYCLES consecutive cycles
//   undefined -> synchronized button is used directly (no debounce counter)
//
// Ports:
//   clk          single clock, all logic on rising edge
//   rst          synchronous active-high reset
//   btn_i        asynchronous external reset button, active-high
//   div_i        per-channel divisors, channel i in [i*DIV_WIDTH +: DIV_WIDTH]
//   div_load_i   per-channel divisor load strobe (captured into pending register)
//   clk_o        divided clocks, registered
//   tick_o       one-cycle pulse at the first cycle of each clk_o high phase
//   soc_rst_n_o  active-low downstream SOC reset
module clock_reset_gen #(
    parameter int NUM_CH          = 2,
    parameter int DIV_WIDTH       = 8,
    parameter int DEFAULT_DIV     = 2,
    parameter int RST_HOLD        = 16,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_i,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   div_i,
    input  logic [NUM_CH-1:0]             div_load_i,
    output logic [NUM_CH-1:0]             clk_o,
    output logic [NUM_CH-1:0]             tick_o,
    output logic                          soc_rst_n_o
);

    // Parameter sanity: a zero-length stretch or debounce window is meaningless.
    if (RST_HOLD < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("clock_reset_gen: RST_HOLD and DEBOUNCE_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    // Reset divisor goes through the same clamp as a runtime load.
    localparam logic [DIV_WIDTH-1:0] RST_DIV =
        (DEFAULT_DIV < 2) ? MIN_DIV : DIV_WIDTH'(DEFAULT_DIV);

    // Divisors 0 and 1 cannot produce a clock with both phases; treat as 2.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] div_q;
        logic [DIV_WIDTH-1:0] pend;
        logic [DIV_WIDTH-1:0] cnt_nxt;
        logic [DIV_WIDTH-1:0] div_nxt;
        logic [DIV_WIDTH-1:0] half_nxt;
        logic [DIV_WIDTH-1:0] din;
        logic                 wrap;
        logic                 clk_q;
        logic                 tick_q;

        assign din  = div_i[i*DIV_WIDTH +: DIV_WIDTH];
        assign wrap = (cnt == div_q - ONE);

        // The pending divisor is only promoted on the wrap, so a period in
        // flight always completes at its original length. Reading the old
        // pend here means a load in the wrap cycle lands one period later.
        always_comb begin
            cnt_nxt = cnt + ONE;
            div_nxt = div_q;
            if (wrap) begin
                cnt_nxt = '0;
                div_nxt = pend;
            end
            // ceil(div/2): odd divisors get the extra cycle in the high phase
            half_nxt = (div_nxt >> 1) + {{(DIV_WIDTH-1){1'b0}}, div_nxt[0]};
        end

        // Outputs are computed from next-state values so the registered
        // clk_o/tick_o line up with the counter value they describe.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                div_q  <= RST_DIV;
                pend   <= RST_DIV;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                div_q  <= div_nxt;
                if (div_load_i[i]) begin
                    pend <= clamp_div(din);
                end
                clk_q  <= (cnt_nxt < half_nxt);
                tick_q <= (cnt_nxt == '0);
            end
        end

        assign clk_o[i]  = clk_q;
        assign tick_o[i] = tick_q;
    end

    // ------------------------------------------------------------------
    // Button synchronizer and optional debounce
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic btn_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

`ifdef CLOCK_RESET_GEN_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_state;

    // Counts consecutive cycles where the synchronized button disagrees with
    // the filtered value; any agreement (a bounce back) restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            db_state <= 1'b0;
        end else if (sync2 != db_state) begin
            if (db_cnt == DB_LAST) begin
                db_state <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign btn_f = db_state;
`else
    assign btn_f = sync2;
`endif

    // ------------------------------------------------------------------
    // Reset stretch FSM
    // ------------------------------------------------------------------
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    rst_state_t        state;
    rst_state_t        state_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STRETCH;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // A press at any point returns to ASSERT; STRETCH is always re-entered
    // with the hold counter cleared, so every release gets the full stretch.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            ASSERT: begin
                if (!btn_f) begin
                    state_nxt = STRETCH;
                    hold_nxt  = '0;
                end
            end
            STRETCH: begin
                if (btn_f) begin
                    state_nxt = ASSERT;
                end else if (hold == HOLD_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            RUN: begin
                if (btn_f) begin
                    state_nxt = ASSERT;
                end
            end
            default: begin
                state_nxt = ASSERT;
            end
        endcase
    end

    // Decoded from the state register alone, so the reset output is glitch-free.
    assign soc_rst_n_o = (state == RUN);

endmodule

// File: tb/tb_clock_reset_gen.sv
// Testbench for clock_reset_gen: divider scoreboard plus reset-sequencing checks.
// Latency: expected channel outputs queued at each drive, compared 1 time unit after the edge.
// Backpressure: n/a.
module tb_clock_reset_gen;

    localparam int NUM_CH = 2;
    localparam int DW     = 8;
    localparam int DEF    = 2;
`ifdef CLOCK_RESET_GEN_DEBOUNCE_EN
    localparam int DB     = 8;
`else
    localparam int DB     = 1024;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    btn_i;
    logic [NUM_CH*DW-1:0]    div_i;
    logic [NUM_CH-1:0]       div_load_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       tick_o;
    logic                    soc_rst_n_o;

    always #5 clk = ~clk;

    clock_reset_gen #(
        .NUM_CH(NUM_CH),
        .DIV_WIDTH(DW),
        .DEFAULT_DIV(DEF),
        .RST_HOLD(16),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_i(btn_i),
        .div_i(div_i),
        .div_load_i(div_load_i),
        .clk_o(clk_o),
        .tick_o(tick_o),
        .soc_rst_n_o(soc_rst_n_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected channel outputs, one entry per driven edge.
    typedef struct packed {
        logic [NUM_CH-1:0] ck;
        logic [NUM_CH-1:0] tk;
    } exp_t;
    exp_t sb[$];

    // Reference divider state, following the channel behaviour description.
    int m_cnt [NUM_CH];
    int m_div [NUM_CH];
    int m_pend[NUM_CH];

    task automatic model_step(input logic r, input logic [NUM_CH-1:0] ld,
                              input logic [NUM_CH*DW-1:0] d);
        exp_t e;
        e = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int din;
            din = int'(d[i*DW +: DW]);
            if (r) begin
                m_cnt[i]  = 0;
                m_div[i]  = DEF;
                m_pend[i] = DEF;
                e.ck[i]   = 1'b0;
                e.tk[i]   = 1'b0;
            end else begin
                if (m_cnt[i] == m_div[i] - 1) begin
                    m_cnt[i] = 0;
                    m_div[i] = m_pend[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                if (ld[i]) m_pend[i] = (din < 2) ? 2 : din;
                e.ck[i] = (m_cnt[i] < (m_div[i] + 1) / 2);
                e.tk[i] = (m_cnt[i] == 0);
            end
        end
        sb.push_back(e);
    endtask

    // One edge: drive at negedge, queue the expectation, return just after the edge.
    task automatic cyc(input logic r, input logic b, input logic [NUM_CH-1:0] ld,
                       input logic [NUM_CH*DW-1:0] d);
        @(negedge clk);
        rst        = r;
        btn_i      = b;
        div_load_i = ld;
        div_i      = d;
        model_step(r, ld, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'b00, 16'h0);
    endtask

    function automatic logic [NUM_CH*DW-1:0] dv(input int c0, input int c1);
        logic [NUM_CH*DW-1:0] r;
        r = {c1[7:0], c0[7:0]};
        return r;
    endfunction

    // Monitor: compare DUT channel outputs against the queued expectation.
    exp_t got_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            got_e = sb.pop_front();
            check("clk_o", 32'(clk_o), 32'(got_e.ck));
            check("tick_o", 32'(tick_o), 32'(got_e.tk));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic seen;
        rst        = 1'b1;
        btn_i      = 1'b0;
        div_i      = '0;
        div_load_i = '0;

        // Reset state
        repeat (3) cyc(1'b1, 1'b0, 2'b00, 16'h0);
        check("rst_soc", 32'(soc_rst_n_o), 32'd0);

        // Release: soc reset rises on the 16th edge with rst low
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 2'b00, 16'h0);
            check("release_soc", 32'(soc_rst_n_o), 32'(k == 16));
        end

        // ch1 to 6, then ch0 to 5 mid-period; scoreboard covers both channels
        cyc(1'b0, 1'b0, 2'b10, dv(0, 6));
        idle(3);
        cyc(1'b0, 1'b0, 2'b01, dv(5, 0));
        idle(16);

        // Two loads before a wrap: last one wins
        for (int k = 0; k < 20 && m_cnt[0] != 0; k++) idle(1);
        cyc(1'b0, 1'b0, 2'b01, dv(3, 0));
        cyc(1'b0, 1'b0, 2'b01, dv(7, 0));
        idle(20);

        // Load 0 clamps to 2
        cyc(1'b0, 1'b0, 2'b10, dv(0, 0));
        idle(16);

        // Load exactly in the wrap cycle takes effect one period later
        for (int k = 0; k < 20 && m_cnt[1] != m_div[1] - 1; k++) idle(1);
        cyc(1'b0, 1'b0, 2'b10, dv(0, 4));
        idle(12);

`ifdef CLOCK_RESET_GEN_DEBOUNCE_EN
        // Button bouncing every 4 cycles never satisfies an 8-cycle window
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'((k / 4) % 2), 2'b00, 16'h0);
            check("bounce_soc", 32'(soc_rst_n_o), 32'd1);
        end
        // Held press is accepted
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 2'b00, 16'h0);
        check("held_soc", 32'(soc_rst_n_o), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            cyc(1'b0, 1'b0, 2'b00, 16'h0);
            seen = soc_rst_n_o;
        end
        check("db_rise", 32'(seen), 32'd1);
`else
        // 1-cycle press at edge 1 (falls at edge 3), second press at edge 10
        // during the stretch restarts it: soc high again only at edge 29.
        for (int k = 1; k <= 35; k++) begin
            cyc(1'b0, (k == 1) || (k == 10), 2'b00, 16'h0);
            check("btn_soc", 32'(soc_rst_n_o), 32'((k < 3) || (k >= 29)));
        end
        seen = 1'b0;
`endif

        // rst mid-period with ch0 at cnt=3 of div 5 and a pending 9
        cyc(1'b0, 1'b0, 2'b01, dv(5, 0));
        for (int k = 0; k < 40 && !(m_div[0] == 5 && m_cnt[0] == 1); k++) idle(1);
        cyc(1'b0, 1'b0, 2'b01, dv(9, 0));
        idle(1);
        cyc(1'b1, 1'b0, 2'b00, 16'h0);
        check("mid_rst_soc", 32'(soc_rst_n_o), 32'd0);
        check("mid_rst_clk0", 32'(clk_o[0]), 32'd0);
        // After release ch0 must run at the default divisor (pending 9 dropped)
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 2'b00, 16'h0);
            check("rerelease_soc", 32'(soc_rst_n_o), 32'(k == 16));
        end
        idle(12);

        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
